// File: rtl/prog_loader.sv
// Program loader: encodes field-level instruction descriptors into 16-bit words
// and writes them sequentially into program memory while holding the CPU.
module prog_loader #(
  parameter int               ADR_W    = 8,
  parameter logic [ADR_W-1:0] BASE_ADR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [2:0]       in_rd,
  input  logic [2:0]       in_rs,
  input  logic [2:0]       in_rt,
  input  logic [7:0]       in_off,
  input  logic [15:0]      in_imm,
  input  logic             in_last,
  output logic [ADR_W-1:0] mem_adr,
  output logic [15:0]      mem_dout,
  output logic             mem_we,
  output logic             cpu_hold,
  output logic             done,
  output logic             overflow,
  output logic [ADR_W:0]   wcount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WR1   = 3'd2,
    WR2   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDI = 4'hA;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] word_reg;
  logic [15:0] imm_reg;
  logic        ldi_reg;
  logic        last_reg;
  logic [15:0] enc_word;
  logic        accept;
  logic        restart;
  logic        at_top;

  assign accept  = in_valid && (state_reg == LOAD);
  assign restart = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
  assign at_top  = (mem_adr == {ADR_W{1'b1}});

  // Operand fields an instruction does not use are forced to zero.
  always_comb begin
    enc_word = {3'b111, in_op, 9'b0};
    case (in_op)
      4'h0, 4'h1:                      enc_word[8:0] = {in_rd, in_rs, in_rt};
      4'h2:                            enc_word[8:0] = {3'b000, in_rs, in_rt};
      4'h3, 4'h4, 4'h5, 4'h6,
      4'h7, 4'h8, 4'h9:                enc_word[8:0] = {in_rd, 3'b000, in_rt};
      4'hA:                            enc_word[8:0] = {in_rd, 6'b0};
      4'hB:                            enc_word[8:0] = 9'b0;
      4'hC, 4'hD, 4'hE:                enc_word[8:0] = {1'b0, in_off};
      4'hF:                            enc_word[8:0] = {6'b0, in_rt};
      default:                         enc_word[8:0] = 9'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A write at the top address is legal only if it is the program's final word.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        if (accept) state_next = WR1;
      end
      WR1: begin
        if (ldi_reg)       state_next = at_top ? ERROR : WR2;
        else if (last_reg) state_next = DONE;
        else               state_next = at_top ? ERROR : LOAD;
      end
      WR2: begin
        if (last_reg) state_next = DONE;
        else          state_next = at_top ? ERROR : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    mem_dout = '0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    overflow = 1'b0;
    case (state_reg)
      LOAD: in_ready = 1'b1;
      WR1: begin
        mem_we   = 1'b1;
        mem_dout = word_reg;
      end
      WR2: begin
        mem_we   = 1'b1;
        mem_dout = imm_reg;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERROR: overflow = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_adr  <= BASE_ADR;
      wcount   <= '0;
      word_reg <= '0;
      imm_reg  <= '0;
      ldi_reg  <= 1'b0;
      last_reg <= 1'b0;
    end else begin
      if (restart) begin
        mem_adr <= BASE_ADR;
        wcount  <= '0;
      end else if (mem_we) begin
        mem_adr <= mem_adr + 1'b1;
        wcount  <= wcount + 1'b1;
      end
      if (accept) begin
        word_reg <= enc_word;
        imm_reg  <= in_imm;
        ldi_reg  <= (in_op == OP_LDI);
        last_reg <= in_last;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program loader and instruction encoder for the 16-bit RISC processor.
- Accepts field-level instruction descriptors over a valid/ready handshake and encodes each into the processor's 16-bit instruction format (opcode in IR[15:9] = 7'h70..7'h7F).
- Writes the encoded words sequentially into program memory, starting at a base address.
- Holds the CPU (cpu_hold) until the program is fully written. It is the writer side of the fetch/decode path.

Parameters:
- ADR_W, 8, program memory address width in bits.
- BASE_ADR, 0, first memory address written after start (ADR_W bits).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a load session; honoured only in IDLE, DONE or ERROR
- in_valid  in  1  descriptor valid
- in_ready  out  1  loader can accept a descriptor
- in_op  in  4  operation; opcode = {3'b111, in_op}
- in_rd  in  3  destination / address register (IR[8:6])
- in_rs  in  3  first source (IR[5:3])
- in_rt  in  3  second source (IR[2:0])
- in_off  in  8  signed branch offset (IR[7:0])
- in_imm  in  16  LDI immediate
- in_last  in  1  descriptor is the final instruction of the program
- mem_adr  out  ADR_W  memory write address
- mem_dout  out  16  memory write data
- mem_we  out  1  memory write enable, one cycle per word
- cpu_hold  out  1  holds the CPU in reset while high
- done  out  1  program loaded
- overflow  out  1  program exceeded memory
- wcount  out  ADR_W+1  words written this session

Behaviour:
- Reset (asynchronous): state IDLE, in_ready=0, mem_adr=BASE_ADR, mem_dout=0, mem_we=0, cpu_hold=1, done=0, overflow=0, wcount=0.

States: IDLE, LOAD, WR1, WR2, DONE, ERROR.
- IDLE: cpu_hold=1. start -> LOAD; mem_adr<=BASE_ADR, wcount<=0.
- LOAD: in_ready=1. When in_valid&in_ready: register the encoded word and the fields, then -> WR1. No acceptance in any other state.
- WR1: mem_we=1 with mem_dout = encoded word at the current mem_adr.
  - If op=LDI (4'hA) -> WR2.
  - Else if in_last -> DONE.
  - Else -> LOAD.
- WR2: mem_we=1 with mem_dout = registered in_imm. Then in_last -> DONE, else -> LOAD.
- Address handling: after every write, mem_adr increments by 1 and wcount increments by 1. Latency from accepted handshake to mem_we is 1 cycle. Throughput is one descriptor per 2 cycles (3 for LDI).
- Overflow: a write at address 2^ADR_W-1 is legal.
  - If that write is not the final word of the program (an LDI immediate still pending, or in_last=0), the next state is ERROR instead of WR2/LOAD. No further write occurs and mem_adr does not wrap into use.
- DONE: done=1, cpu_hold=0, in_ready=0. start -> LOAD (cpu_hold returns to 1, done=0).
- ERROR: overflow=1, cpu_hold=1, in_ready=0. start -> LOAD and clears overflow.
- start in LOAD/WR1/WR2 is ignored.
- Reset mid-session aborts immediately. A partial write is dropped; mem_we goes to 0 asynchronously.

Encoding (rd=IR[8:6], rs=IR[5:3], rt=IR[2:0]):
- ADD 0, SUB 1: {op7, rd, rs, rt}
- CMP 2: {op7, 3'b000, rs, rt}
- MOV 3, SHL 4, SHR 5, INC 6, DEC 7, LD 8: {op7, rd, 3'b000, rt}
- STO 9: {op7, rd, 3'b000, rt}, where rd is the address register.
- LDI A: {op7, rd, 6'b0}, followed by in_imm as a second word.
- HALT B: {op7, 9'b0}
- JE C, JNE D, JC E: {op7, 1'b0, in_off}
- JMP F: {op7, 6'b0, rt}
- Unused fields are forced to 0 regardless of input.

Test Plan:
- Reset, start, one descriptor ADD rd=1 rs=2 rt=3 with last=1:
  - Expect mem_we at adr 0 with data 16'hE053.
  - Expect wcount=1, then done=1 and cpu_hold=0.
- LDI rd=4, imm=16'h1234, then HALT with last:
  - Expect writes adr0=16'hF500, adr1=16'h1234, adr2=16'hF600.
  - Expect wcount=3.
- JNE off=8'hFC and JMP rt=5 with rd/rs set to 7:
  - Expect 16'hFAFC, then 16'hFE05 (ignored fields are zero).
  - Hold in_valid high with a new descriptor during WR1: expect in_ready=0 and no acceptance.
- ADR_W=2, five one-word descriptors:
  - Expect four writes at adr 0..3.
  - Expect ERROR: overflow=1, cpu_hold=1, no fifth write.
  - start -> overflow clears and loading restarts at adr 0.
- ADR_W=2, three MOVs then LDI at adr 3:
  - Expect opcode word written at adr 3, then ERROR with no immediate write.
- Assert reset during WR2:
  - Expect mem_we=0 immediately and all outputs at reset values.
  - A following start restarts at BASE_ADR.
